// File: rtl/fabric_switch_cfg_ctrl.sv
// Runtime route-table loader for one fabric_switch: streams config words into a shadow
// register, validates the expanded table, drains switch traffic, then commits atomically.
module fabric_switch_cfg_ctrl #(
   parameter int                                 NUM_INPUTS     = 4,
   parameter int                                 NUM_OUTPUTS    = 4,
   parameter logic [NUM_OUTPUTS*NUM_INPUTS-1:0]  CONNECTIVITY   = '1,
   parameter int                                 CFG_WORD_WIDTH = 32,
   parameter int                                 DRAIN_CYCLES   = 2,
   localparam int                                NUM_CONNECTED  = $countones(CONNECTIVITY)
) (
   input  logic                      clk,
   input  logic                      rst,
   // cfg_* handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
   // the source must hold cfg_valid/cfg_data/cfg_last stable until that edge.
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [CFG_WORD_WIDTH-1:0] cfg_data,
   input  logic                      cfg_last,
   output logic [NUM_CONNECTED-1:0]  cfg_route_table,
   output logic                      sw_hold,
   output logic                      cfg_busy,
   output logic                      cfg_done,
   output logic                      error_valid,
   output logic [15:0]               error_code,
   output logic [2:0]                dbg_state
);

   localparam int NUM_WORDS = (NUM_CONNECTED + CFG_WORD_WIDTH - 1) / CFG_WORD_WIDTH;
   localparam int SHADOW_W  = NUM_WORDS * CFG_WORD_WIDTH;
   localparam int CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int DW        = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

   localparam logic [15:0] ERR_MULTI_OUT = 16'd1;
   localparam logic [15:0] ERR_MULTI_IN  = 16'd2;
   localparam logic [15:0] ERR_FRAMING   = 16'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CHECK  = 3'd2,
      S_DRAIN  = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic [SHADOW_W-1:0]        shadow_q, shadow_d;
   logic [CW-1:0]              word_cnt_q, word_cnt_d;
   logic [DW-1:0]              drain_cnt_q, drain_cnt_d;
   logic [NUM_CONNECTED-1:0]   table_q, table_d;
   logic                       err_valid_q, err_valid_d;
   logic [15:0]                err_code_q, err_code_d;

   logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] route;
   logic                       multi_out;
   logic                       multi_in;

   // Packed shadow bits fill only the physically present links, out-major, in-minor.
   always_comb begin
      int idx;
      idx   = 0;
      route = '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (CONNECTIVITY[o*NUM_INPUTS+i]) begin
               route[o][i] = shadow_q[idx];
               idx++;
            end
         end
      end
   end

   always_comb begin
      logic seen;
      multi_out = 1'b0;
      multi_in  = 1'b0;
      seen      = 1'b0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
         seen = 1'b0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (route[o][i]) begin
               if (seen) multi_out = 1'b1;
               seen = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_INPUTS; i++) begin
         seen = 1'b0;
         for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (route[o][i]) begin
               if (seen) multi_in = 1'b1;
               seen = 1'b1;
            end
         end
      end
   end

   always_comb begin
      logic [CW-1:0]  k;
      logic           accept;
      logic           is_final;
      logic           err_set;
      logic [15:0]    err_new;

      state_d     = state_q;
      shadow_d    = shadow_q;
      word_cnt_d  = word_cnt_q;
      drain_cnt_d = drain_cnt_q;
      table_d     = table_q;
      err_set     = 1'b0;
      err_new     = 16'd0;

      k        = (state_q == S_IDLE) ? '0 : word_cnt_q;
      accept   = cfg_valid && cfg_ready;
      is_final = (k == CW'(NUM_WORDS - 1));

      unique case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               if (state_q == S_IDLE) shadow_d = '0;
               shadow_d[k*CFG_WORD_WIDTH +: CFG_WORD_WIDTH] = cfg_data;
               if (is_final && cfg_last) begin
                  state_d    = S_CHECK;
                  word_cnt_d = '0;
               end else if (is_final || cfg_last) begin
                  // Mis-framed load: drop everything gathered so far.
                  err_set    = 1'b1;
                  err_new    = ERR_FRAMING;
                  shadow_d   = '0;
                  word_cnt_d = '0;
                  state_d    = S_IDLE;
               end else begin
                  word_cnt_d = k + CW'(1);
                  state_d    = S_LOAD;
               end
            end
         end
         S_CHECK: begin
            if (multi_out || multi_in) begin
               err_set = 1'b1;
               err_new = multi_out ? ERR_MULTI_OUT : ERR_MULTI_IN;
               state_d = S_IDLE;
            end else if (DRAIN_CYCLES == 0) begin
               state_d = S_COMMIT;
            end else begin
               drain_cnt_d = DW'(DRAIN_CYCLES);
               state_d     = S_DRAIN;
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q - DW'(1);
            if (drain_cnt_q <= DW'(1)) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            table_d = shadow_q[NUM_CONNECTED-1:0];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Only the first error since reset is recorded.
      err_valid_d = err_valid_q;
      err_code_d  = err_code_q;
      if (err_set && !err_valid_q) begin
         err_valid_d = 1'b1;
         err_code_d  = err_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shadow_q    <= '0;
         word_cnt_q  <= '0;
         drain_cnt_q <= '0;
         table_q     <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         word_cnt_q  <= word_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         table_q     <= table_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   assign cfg_ready       = !rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
   assign sw_hold         = (state_q == S_DRAIN) || (state_q == S_COMMIT);
   assign cfg_busy        = (state_q != S_IDLE);
   assign cfg_done        = (state_q == S_COMMIT);
   assign cfg_route_table = table_q;
   assign error_valid     = err_valid_q;
   assign error_code      = err_code_q;
   assign dbg_state       = state_q;

endmodule
